// File: rtl/gpu_pkg.sv
// Definitions shared by the fma dot-product sequencer and its parent.
// The fixed-point position matters only to the fma arithmetic; it is kept here for the parent.
package gpu_pkg;

   localparam int unsigned DEF_WIDTH       = 16;
   localparam int unsigned DEF_FIXED_POINT = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that tracks operand reads in flight.
// Each stage carries a data-valid bit and a first-element-of-command bit.
module valid_delay_line #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic first_i,
   output logic valid_o,
   output logic first_o
);

   logic [1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= '{default: 2'b00};
      end else begin
         stage_q[0] <= {valid_i, first_i};
         for (int k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign valid_o = stage_q[DEPTH-1][1];
   assign first_o = stage_q[DEPTH-1][0];

endmodule

// File: rtl/fma_dot_sequencer.sv
// Drives one fma through a dot product of two vectors held in a dual-bank operand RAM.
// One read per cycle; the fma accumulates and the final sum is captured into result_out.
module fma_dot_sequencer
   import gpu_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LEN_W  = 9,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic [ADDR_W-1:0] base_addr_in,
   input  logic [LEN_W-1:0]  len_in,
   output logic              busy_out,
   output logic [ADDR_W-1:0] rd_addr_out,
   output logic              rd_en_out,
   input  logic [WIDTH-1:0]  rd_a_in,
   input  logic [WIDTH-1:0]  rd_b_in,
   output logic [WIDTH-1:0]  fma_a_out,
   output logic [WIDTH-1:0]  fma_b_out,
   output logic [WIDTH-1:0]  fma_c_out,
   output logic              fma_a_valid_out,
   output logic              fma_b_valid_out,
   output logic              fma_c_valid_out,
   output logic              fma_compute_out,
   input  logic [WIDTH-1:0]  fma_out_in,
   output logic [WIDTH-1:0]  result_out,
   output logic              result_valid_out
);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [LEN_W-1:0]  cmp_cnt_q, cmp_cnt_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              rd_en;
   logic              data_valid;
   logic              data_first;

   assign rd_en = (state_q == ISSUE);

   valid_delay_line #(
      .DEPTH (RD_LAT)
   ) u_valid_delay (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .valid_i (rd_en),
      .first_i (rd_en && (issue_cnt_q == '0)),
      .valid_o (data_valid),
      .first_o (data_first)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         cmp_cnt_q   <= '0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         cmp_cnt_q   <= cmp_cnt_d;
         result_q    <= result_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      cmp_cnt_d   = data_valid ? cmp_cnt_q + 1'b1 : cmp_cnt_q;
      result_d    = result_q;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               base_d      = base_addr_in;
               len_d       = len_in;
               issue_cnt_d = '0;
               cmp_cnt_d   = '0;
               if (len_in == '0) begin
                  result_d = '0;
                  state_d  = DONE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == len_q - 1'b1) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // All computes counted means the last one was the previous cycle,
            // so the fma output now holds the full sum.
            if (cmp_cnt_q == len_q) begin
               result_d = fma_out_in;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_out         = (state_q != IDLE);
   assign result_valid_out = (state_q == DONE);
   assign result_out       = result_q;
   assign rd_en_out        = rd_en;
   assign rd_addr_out      = base_q + issue_cnt_q[ADDR_W-1:0];

   assign fma_a_out       = data_valid ? rd_a_in : '0;
   assign fma_b_out       = data_valid ? rd_b_in : '0;
   assign fma_c_out       = '0;
   assign fma_a_valid_out = data_valid;
   assign fma_b_valid_out = data_valid;
   assign fma_c_valid_out = data_valid && data_first;
   assign fma_compute_out = data_valid;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Bench for fma_dot_sequencer: behavioural operand RAM and fma around the DUT,
// directed scenarios followed by random commands checked against a plain dot-product model.
module tb_fma_dot_sequencer;

   localparam int RD_LAT = 2;
   localparam int FRAC   = 10;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  base_in;
   logic [8:0]  len_in;
   logic        busy;
   logic [7:0]  rd_addr;
   logic        rd_en;
   logic [15:0] rd_a, rd_b;
   logic [15:0] fma_a, fma_b, fma_c;
   logic        fma_a_valid, fma_b_valid, fma_c_valid, fma_compute;
   logic [15:0] fma_out;
   logic [15:0] result;
   logic        result_valid;

   int tests = 0;
   int fails = 0;

   fma_dot_sequencer #(
      .WIDTH  (16),
      .ADDR_W (8),
      .LEN_W  (9),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .start_in         (start),
      .base_addr_in     (base_in),
      .len_in           (len_in),
      .busy_out         (busy),
      .rd_addr_out      (rd_addr),
      .rd_en_out        (rd_en),
      .rd_a_in          (rd_a),
      .rd_b_in          (rd_b),
      .fma_a_out        (fma_a),
      .fma_b_out        (fma_b),
      .fma_c_out        (fma_c),
      .fma_a_valid_out  (fma_a_valid),
      .fma_b_valid_out  (fma_b_valid),
      .fma_c_valid_out  (fma_c_valid),
      .fma_compute_out  (fma_compute),
      .fma_out_in       (fma_out),
      .result_out       (result),
      .result_valid_out (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operand RAM with RD_LAT-cycle read latency; not reset, so stale reads stay in flight.
   logic [15:0] ram_a [256];
   logic [15:0] ram_b [256];
   logic [7:0]  pipe_addr [RD_LAT];
   logic        pipe_en   [RD_LAT];

   always @(posedge clk) begin
      pipe_en[0]   <= rd_en;
      pipe_addr[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_en[i]   <= pipe_en[i-1];
         pipe_addr[i] <= pipe_addr[i-1];
      end
   end

   assign rd_a = pipe_en[RD_LAT-1] ? ram_a[pipe_addr[RD_LAT-1]] : 16'hDEAD;
   assign rd_b = pipe_en[RD_LAT-1] ? ram_b[pipe_addr[RD_LAT-1]] : 16'hBEEF;

   // Behavioural fma: acc = (c_valid ? c : acc) + (a*b >> FRAC), registered output.
   logic [15:0] fma_acc;
   logic [31:0] fma_prod;
   assign fma_prod = {16'd0, fma_a} * {16'd0, fma_b};

   always @(posedge clk) begin
      if (rst) fma_acc <= 16'd0;
      else if (fma_compute) fma_acc <= (fma_c_valid ? fma_c : fma_acc) + 16'(fma_prod >> FRAC);
   end
   assign fma_out = fma_acc;

   // Activity monitors, cleared by the stimulus before each command.
   int         n_rden, n_compute, n_cvalid, n_pulse, n_strobe_err;
   logic [7:0] addr_log [$];

   always @(posedge clk) begin
      if (!rst) begin
         if (rd_en) begin
            n_rden = n_rden + 1;
            addr_log.push_back(rd_addr);
         end
         if (fma_compute) n_compute = n_compute + 1;
         if (fma_c_valid) n_cvalid = n_cvalid + 1;
         if (result_valid) n_pulse = n_pulse + 1;
         if (fma_a_valid !== fma_compute || fma_b_valid !== fma_compute) n_strobe_err = n_strobe_err + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: sum of truncated fixed-point products over the wrapped address window.
   function automatic logic [15:0] ref_dot(input logic [7:0] base, input int len);
      logic [31:0] acc;
      logic [31:0] prod;
      logic [7:0]  ad;
      acc = 32'd0;
      for (int i = 0; i < len; i++) begin
         ad   = 8'(int'(base) + i);
         prod = 32'(ram_a[ad]) * 32'(ram_b[ad]);
         acc  = acc + (prod >> FRAC);
      end
      return acc[15:0];
   endfunction

   task automatic clear_monitors();
      n_rden = 0; n_compute = 0; n_cvalid = 0; n_pulse = 0; n_strobe_err = 0;
      addr_log.delete();
   endtask

   task automatic run_cmd(input logic [7:0] base, input logic [8:0] len, input bit poke,
                          output logic [15:0] res);
      logic [15:0] exp_res;
      int          k, exp_k, bad;
      bit          seen;
      exp_res = ref_dot(base, int'(len));
      exp_k   = (len == 9'd0) ? 1 : int'(len) + RD_LAT + 2;
      clear_monitors();
      @(negedge clk);
      start = 1'b1; base_in = base; len_in = len;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      seen = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      while (k <= exp_k + 8) begin
         if (result_valid) begin
            seen = 1'b1;
            break;
         end
         if (poke && k == 2) begin
            start = 1'b1; base_in = 8'h55; len_in = 9'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("pulse_seen", 32'(seen), 32'd1);
      check("latency", 32'(k), 32'(exp_k));
      check("result", 32'(result), 32'(exp_res));
      check("busy_in_done", 32'(busy), 32'd1);
      res = result;
      if (poke) begin
         start = 1'b1; base_in = 8'h00; len_in = 9'd1;
      end
      @(negedge clk);
      start = 1'b0;
      check("pulse_width", 32'(result_valid), 32'd0);
      check("busy_drop", 32'(busy), 32'd0);
      check("result_hold", 32'(result), 32'(exp_res));
      @(negedge clk);
      check("rd_en_count", 32'(n_rden), 32'(len));
      check("compute_count", 32'(n_compute), 32'(len));
      check("c_valid_count", 32'(n_cvalid), (len != 9'd0) ? 32'd1 : 32'd0);
      check("pulse_count", 32'(n_pulse), 32'd1);
      check("strobe_align", 32'(n_strobe_err), 32'd0);
      bad = 0;
      for (int i = 0; i < addr_log.size(); i++) begin
         if (addr_log[i] !== 8'(int'(base) + i)) bad++;
      end
      check("addr_seq", 32'(bad), 32'd0);
      $display("[TB] cmd base=%02h len=%0d poke=%0d result=%04h expected=%04h latency=%0d",
               base, len, poke, result, exp_res, k);
   endtask

   initial begin
      logic [15:0] res;
      logic [7:0]  rb;
      logic [8:0]  rl;

      rst = 1'b1; start = 1'b0; base_in = '0; len_in = '0;
      for (int i = 0; i < 256; i++) begin
         ram_a[i] = 16'($urandom_range(0, 16'hFFFF));
         ram_b[i] = 16'($urandom_range(0, 16'hFFFF));
      end
      ram_a[0] = 16'h0800; ram_b[0] = 16'h0600;
      ram_a[1] = 16'h1480; ram_b[1] = 16'h1800;
      clear_monitors();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_compute", 32'(fma_compute), 32'd0);
      check("rst_c_valid", 32'(fma_c_valid), 32'd0);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_fma_a", 32'(fma_a), 32'd0);

      // Single element, then back-to-back two elements (accumulator must clear).
      run_cmd(8'h00, 9'd1, 1'b0, res);
      check("dir_len1", 32'(res), 32'h0C00);
      run_cmd(8'h00, 9'd2, 1'b0, res);
      check("dir_len2", 32'(res), 32'h8700);

      // Zero length: immediate zero result.
      run_cmd(8'h00, 9'd0, 1'b0, res);
      check("dir_len0", 32'(res), 32'h0000);

      // Address wrap with start pokes while busy.
      run_cmd(8'hFF, 9'd2, 1'b1, res);

      // Reset during ISSUE.
      clear_monitors();
      @(negedge clk);
      start = 1'b1; base_in = 8'h10; len_in = 9'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_rd_en", 32'(rd_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_rd_en", 32'(rd_en), 32'd0);
      check("rstmid_compute", 32'(fma_compute), 32'd0);
      check("rstmid_result_valid", 32'(result_valid), 32'd0);
      clear_monitors();
      repeat (RD_LAT + 6) @(negedge clk);
      check("rstmid_no_compute", 32'(n_compute), 32'd0);
      check("rstmid_no_pulse", 32'(n_pulse), 32'd0);
      check("rstmid_no_read", 32'(n_rden), 32'd0);
      run_cmd(8'h00, 9'd2, 1'b0, res);
      check("post_rst_len2", 32'(res), 32'h8700);

      // Random commands, including the maximum length.
      for (int r = 0; r < 10; r++) begin
         rb = 8'($urandom_range(0, 255));
         rl = (r == 0) ? 9'd256 : 9'($urandom_range(1, 40));
         run_cmd(rb, rl, (r % 3) == 1, res);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
